pll_sample_scheduler: RTL and testbench

Sample-rate scheduler for the AXIS SOGI-PLL datapath. Generates a programmable periodic sample tick and sequences one PLL computation per tick: it launches the core through an AXIS-style start handshake, waits for the core's done pulse with a timeout, then presents a result-valid handshake downstream. Ticks that arrive while a computation is still in flight are dropped and counted as overruns. The block replaces free-running control-clock strobes with a single-clock, fully synchronous schedule.

---
 rtl/pll_sched_pkg.sv | 19 +
 rtl/pll_tick_gen.sv | 57 +++++
 rtl/pll_sample_scheduler.sv | 133 +++++++++++++
 tb/tb_pll_sample_scheduler.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/pll_sched_pkg.sv
// Shared definitions for the PLL sample scheduler: FSM encoding,
// default widths and the shortest legal tick period.
package pll_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ISSUE     = 2'd1,
    ST_WAIT_DONE = 2'd2,
    ST_OUTPUT    = 2'd3
  } sched_state_t;

  localparam int DEF_DIV_WIDTH = 16;
  localparam int DEF_TO_WIDTH  = 12;
  localparam int DEF_CNT_WIDTH = 8;

  // A period of 1 would tick every cycle and leave the counter no room to wrap.
  localparam int MIN_PERIOD    = 2;

endpackage

// File: rtl/pll_tick_gen.sv
// Programmable sample-tick generator. The counter runs 0..period_q-1 while
// enabled; the period is reloaded only at wrap or when enable rises, so a
// new cfg_period never truncates or stretches the period in progress.
module pll_tick_gen
  import pll_sched_pkg::*;
#(
  parameter int DIV_WIDTH = DEF_DIV_WIDTH
) (
  input  logic                 Clk,
  input  logic                 Resetn,
  input  logic                 enable,
  input  logic [DIV_WIDTH-1:0] cfg_period,
  output logic                 tick
);

  logic [DIV_WIDTH-1:0] count;
  logic [DIV_WIDTH-1:0] period_q;
  logic [DIV_WIDTH-1:0] period_sel;
  logic                 enable_q;
  logic                 at_end;

  // Clamp the requested period to the minimum legal value.
  always_comb begin
    if (cfg_period < DIV_WIDTH'(MIN_PERIOD)) begin
      period_sel = DIV_WIDTH'(MIN_PERIOD);
    end else begin
      period_sel = cfg_period;
    end
  end

  // Tick is a decode of registered state gated by enable, so it lands in
  // the very cycle the counter sits at its terminal value.
  assign at_end = (count == (period_q - DIV_WIDTH'(1)));
  assign tick   = enable & at_end;

  // Period counter, period latch and enable edge history.
  always_ff @(posedge Clk or negedge Resetn) begin
    if (!Resetn) begin
      count    <= {DIV_WIDTH{1'b0}};
      period_q <= DIV_WIDTH'(MIN_PERIOD);
      enable_q <= 1'b0;
    end else begin
      enable_q <= enable;
      if (!enable || at_end) begin
        count <= {DIV_WIDTH{1'b0}};
      end else begin
        count <= count + DIV_WIDTH'(1);
      end
      if (enable && (at_end || !enable_q)) begin
        period_q <= period_sel;
      end else begin
        period_q <= period_q;
      end
    end
  end

endmodule

// File: rtl/pll_sample_scheduler.sv
// Sample-rate scheduler: one PLL computation per tick, launched through a
// start handshake, guarded by a done timeout, and handed downstream through
// a result-valid handshake. Ticks arriving mid-sequence are counted as
// overruns and otherwise dropped.
module pll_sample_scheduler
  import pll_sched_pkg::*;
#(
  parameter int DIV_WIDTH = DEF_DIV_WIDTH,
  parameter int TO_WIDTH  = DEF_TO_WIDTH,
  parameter int CNT_WIDTH = DEF_CNT_WIDTH
) (
  input  logic                 Clk,
  input  logic                 Resetn,
  input  logic                 enable,
  input  logic [DIV_WIDTH-1:0] cfg_period,
  input  logic [TO_WIDTH-1:0]  cfg_timeout,
  input  logic                 clear_errors,
  output logic                 tick,
  output logic                 start_tvalid,
  input  logic                 start_tready,
  input  logic                 core_done,
  output logic                 out_data_valid,
  input  logic                 out_data_ready,
  output logic                 busy,
  output logic [CNT_WIDTH-1:0] overrun_cnt,
  output logic                 err_timeout
);

  sched_state_t        state;
  logic [TO_WIDTH-1:0] to_cnt;
  logic [TO_WIDTH-1:0] to_next;
  logic                timeout_hit;
  logic                timeout_evt;
  logic                overrun_evt;

  pll_tick_gen #(
    .DIV_WIDTH (DIV_WIDTH)
  ) u_tick_gen (
    .Clk        (Clk),
    .Resetn     (Resetn),
    .enable     (enable),
    .cfg_period (cfg_period),
    .tick       (tick)
  );

  // Timeout terminal decode: the cfg_timeout-th cycle spent in WAIT_DONE.
  always_comb begin
    to_next     = to_cnt + TO_WIDTH'(1);
    timeout_hit = (cfg_timeout != {TO_WIDTH{1'b0}}) && (to_next == cfg_timeout);
    timeout_evt = (state == ST_WAIT_DONE) && !core_done && timeout_hit;
    overrun_evt = tick && (state != ST_IDLE);
  end

  // Sequencing FSM; handshake valids and busy are registered from the next state.
  always_ff @(posedge Clk or negedge Resetn) begin
    if (!Resetn) begin
      state          <= ST_IDLE;
      start_tvalid   <= 1'b0;
      out_data_valid <= 1'b0;
      busy           <= 1'b0;
      to_cnt         <= {TO_WIDTH{1'b0}};
    end else begin
      case (state)
        ST_IDLE: begin
          if (tick) begin
            state        <= ST_ISSUE;
            start_tvalid <= 1'b1;
            busy         <= 1'b1;
          end
        end
        ST_ISSUE: begin
          if (start_tready) begin
            state        <= ST_WAIT_DONE;
            start_tvalid <= 1'b0;
            to_cnt       <= {TO_WIDTH{1'b0}};
          end
        end
        ST_WAIT_DONE: begin
          // A done arriving on the terminal cycle still counts as on time.
          if (core_done) begin
            state          <= ST_OUTPUT;
            out_data_valid <= 1'b1;
          end else if (timeout_hit) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end else begin
            to_cnt <= to_next;
          end
        end
        ST_OUTPUT: begin
          if (out_data_ready) begin
            state          <= ST_IDLE;
            out_data_valid <= 1'b0;
            busy           <= 1'b0;
          end
        end
        default: begin
          state          <= ST_IDLE;
          start_tvalid   <= 1'b0;
          out_data_valid <= 1'b0;
          busy           <= 1'b0;
        end
      endcase
    end
  end

  // Sticky timeout flag; a timeout in the clearing cycle survives the clear.
  always_ff @(posedge Clk or negedge Resetn) begin
    if (!Resetn) begin
      err_timeout <= 1'b0;
    end else if (timeout_evt) begin
      err_timeout <= 1'b1;
    end else if (clear_errors) begin
      err_timeout <= 1'b0;
    end else begin
      err_timeout <= err_timeout;
    end
  end

  // Saturating overrun counter; an overrun in the clearing cycle leaves a count of one.
  always_ff @(posedge Clk or negedge Resetn) begin
    if (!Resetn) begin
      overrun_cnt <= {CNT_WIDTH{1'b0}};
    end else if (clear_errors) begin
      overrun_cnt <= overrun_evt ? CNT_WIDTH'(1) : {CNT_WIDTH{1'b0}};
    end else if (overrun_evt && (overrun_cnt != {CNT_WIDTH{1'b1}})) begin
      overrun_cnt <= overrun_cnt + CNT_WIDTH'(1);
    end else begin
      overrun_cnt <= overrun_cnt;
    end
  end

endmodule

// File: tb/tb_pll_sample_scheduler.sv
// Directed bench for pll_sample_scheduler. Window Wn is the interval that
// starts 1 time unit after the n-th rising edge following reset release
// (W0 is the window in which Resetn rises). Inputs change and outputs are
// sampled at the start of each window.
module tb_pll_sample_scheduler;

  logic        Clk = 1'b0;
  logic        Resetn;
  logic        enable;
  logic [15:0] cfg_period;
  logic [11:0] cfg_timeout;
  logic        clear_errors;
  logic        tick;
  logic        start_tvalid;
  logic        start_tready;
  logic        core_done;
  logic        out_data_valid;
  logic        out_data_ready;
  logic        busy;
  logic [7:0]  overrun_cnt;
  logic        err_timeout;

  int checks   = 0;
  int failures = 0;

  pll_sample_scheduler dut (
    .Clk            (Clk),
    .Resetn         (Resetn),
    .enable         (enable),
    .cfg_period     (cfg_period),
    .cfg_timeout    (cfg_timeout),
    .clear_errors   (clear_errors),
    .tick           (tick),
    .start_tvalid   (start_tvalid),
    .start_tready   (start_tready),
    .core_done      (core_done),
    .out_data_valid (out_data_valid),
    .out_data_ready (out_data_ready),
    .busy           (busy),
    .overrun_cnt    (overrun_cnt),
    .err_timeout    (err_timeout)
  );

  always #5 Clk = ~Clk;

  task automatic chk_bit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic chk_cnt(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic hold_reset();
    Resetn = 1'b0;
    repeat (2) @(posedge Clk);
    #1;
  endtask

  initial begin
    // ---------------- Test 1: reset values, then P=10 steady operation
    enable = 1'b1; cfg_period = 16'd10; cfg_timeout = 12'd0; clear_errors = 1'b0;
    start_tready = 1'b1; core_done = 1'b0; out_data_ready = 1'b1;
    hold_reset();
    chk_bit("rst_tick", tick, 1'b0);
    chk_bit("rst_start_tvalid", start_tvalid, 1'b0);
    chk_bit("rst_out_valid", out_data_valid, 1'b0);
    chk_bit("rst_busy", busy, 1'b0);
    chk_cnt("rst_overrun", overrun_cnt, 8'd0);
    chk_bit("rst_err", err_timeout, 1'b0);
    Resetn = 1'b1;
    // Tick at W9/19/29/39, handshake next window, done 3 windows later, accept next.
    for (int i = 0; i < 40; i++) begin
      if (i > 0) step();
      core_done = (i >= 13) && (i % 10 == 3);
      chk_bit($sformatf("t1_tick_w%0d", i), tick, (i % 10 == 9));
      chk_bit($sformatf("t1_start_w%0d", i), start_tvalid, (i >= 10) && (i % 10 == 0));
      chk_bit($sformatf("t1_valid_w%0d", i), out_data_valid, (i >= 14) && (i % 10 == 4));
      chk_bit($sformatf("t1_busy_w%0d", i), busy, (i >= 10) && (i % 10 <= 4));
    end
    core_done = 1'b0;
    chk_cnt("t1_overrun", overrun_cnt, 8'd0);

    // ---------------- Test 2: P=4, downstream stalls 20 windows
    enable = 1'b1; cfg_period = 16'd4; cfg_timeout = 12'd0; clear_errors = 1'b0;
    start_tready = 1'b1; core_done = 1'b0; out_data_ready = 1'b0;
    hold_reset();
    Resetn = 1'b1;
    for (int i = 0; i < 27; i++) begin
      if (i > 0) step();
      core_done      = (i == 5);
      out_data_ready = (i == 26);
      chk_bit($sformatf("t2_tick_w%0d", i), tick, (i % 4 == 3));
      if (i == 4) chk_bit("t2_start_w4", start_tvalid, 1'b1);
      if (i >= 6) chk_bit($sformatf("t2_valid_hold_w%0d", i), out_data_valid, 1'b1);
      if (i == 8) chk_cnt("t2_overrun_w8", overrun_cnt, 8'd1);
    end
    chk_cnt("t2_overrun_w26", overrun_cnt, 8'd5);
    step();   // W27: back in IDLE and the tick here is accepted
    out_data_ready = 1'b0;
    chk_bit("t2_valid_w27", out_data_valid, 1'b0);
    chk_bit("t2_busy_w27", busy, 1'b0);
    chk_bit("t2_tick_w27", tick, 1'b1);
    step();   // W28
    chk_bit("t2_start_w28", start_tvalid, 1'b1);
    chk_cnt("t2_overrun_w28", overrun_cnt, 8'd5);

    // ---------------- Test 3: timeout 8, core never completes
    enable = 1'b1; cfg_period = 16'd10; cfg_timeout = 12'd8; clear_errors = 1'b0;
    start_tready = 1'b1; core_done = 1'b0; out_data_ready = 1'b1;
    hold_reset();
    Resetn = 1'b1;
    for (int i = 0; i < 23; i++) begin
      if (i > 0) step();
      enable       = (i < 10);
      clear_errors = (i == 18) || (i == 21);
      if (i == 11) chk_bit("t3_start_w11", start_tvalid, 1'b0);
      if (i == 11) chk_bit("t3_busy_w11", busy, 1'b1);
      if (i == 18) chk_bit("t3_err_w18", err_timeout, 1'b0);
      if (i == 18) chk_bit("t3_busy_w18", busy, 1'b1);
      if (i == 19) chk_bit("t3_err_w19", err_timeout, 1'b1);
      if (i == 19) chk_bit("t3_busy_w19", busy, 1'b0);
      if (i == 20) chk_bit("t3_err_w20", err_timeout, 1'b1);
      if (i == 22) chk_bit("t3_err_w22", err_timeout, 1'b0);
    end
    clear_errors = 1'b0;

    // ---------------- Test 4: done on the timeout-terminal cycle
    enable = 1'b1; cfg_period = 16'd10; cfg_timeout = 12'd8; clear_errors = 1'b0;
    start_tready = 1'b1; core_done = 1'b0; out_data_ready = 1'b1;
    hold_reset();
    Resetn = 1'b1;
    for (int i = 0; i < 21; i++) begin
      if (i > 0) step();
      enable    = (i < 10);
      core_done = (i == 18);
      if (i == 19) chk_bit("t4_valid_w19", out_data_valid, 1'b1);
      if (i == 19) chk_bit("t4_err_w19", err_timeout, 1'b0);
      if (i == 20) chk_bit("t4_valid_w20", out_data_valid, 1'b0);
      if (i == 20) chk_bit("t4_busy_w20", busy, 1'b0);
      if (i == 20) chk_bit("t4_err_w20", err_timeout, 1'b0);
    end
    core_done = 1'b0;

    // ---------------- Test 5: period 10->6 mid-period, then 0 (=2); overrun clear
    enable = 1'b1; cfg_period = 16'd10; cfg_timeout = 12'd0; clear_errors = 1'b0;
    start_tready = 1'b0; core_done = 1'b0; out_data_ready = 1'b1;
    hold_reset();
    Resetn = 1'b1;
    for (int i = 0; i < 43; i++) begin
      if (i > 0) step();
      cfg_period   = (i < 12) ? 16'd10 : ((i < 32) ? 16'd6 : 16'd0);
      clear_errors = (i == 31);
      chk_bit($sformatf("t5_tick_w%0d", i), tick,
              (i == 9) || (i == 19) || (i == 25) || (i == 31) ||
              (i == 37) || (i == 39) || (i == 41));
      if (i == 20) chk_cnt("t5_overrun_w20", overrun_cnt, 8'd1);
      if (i == 26) chk_cnt("t5_overrun_w26", overrun_cnt, 8'd2);
      if (i == 32) chk_cnt("t5_overrun_w32", overrun_cnt, 8'd1);
    end
    clear_errors = 1'b0;
    chk_cnt("t5_overrun_w42", overrun_cnt, 8'd4);
    chk_bit("t5_start_held_w42", start_tvalid, 1'b1);

    // ---------------- Test 6: asynchronous reset during OUTPUT
    enable = 1'b1; cfg_period = 16'd10; cfg_timeout = 12'd0; clear_errors = 1'b0;
    start_tready = 1'b1; core_done = 1'b0; out_data_ready = 1'b0;
    hold_reset();
    Resetn = 1'b1;
    for (int i = 0; i < 15; i++) begin
      if (i > 0) step();
      core_done = (i == 12);
      if (i >= 13) chk_bit($sformatf("t6_valid_w%0d", i), out_data_valid, 1'b1);
    end
    core_done = 1'b0;
    #2;
    Resetn = 1'b0;
    #1;
    chk_bit("t6_async_valid", out_data_valid, 1'b0);
    chk_bit("t6_async_busy", busy, 1'b0);
    chk_bit("t6_async_start", start_tvalid, 1'b0);
    out_data_ready = 1'b1;
    hold_reset();
    Resetn = 1'b1;
    for (int i = 0; i < 11; i++) begin
      if (i > 0) step();
      chk_bit($sformatf("t6_tick_w%0d", i), tick, (i == 9));
    end
    chk_bit("t6_start_w10", start_tvalid, 1'b1);
    chk_cnt("t6_overrun_w10", overrun_cnt, 8'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
